tdc_meas_ctrl: RTL
==================

Name: tdc_meas_ctrl

Overview:
- Measurement sequencer for the 48-step inverter-chain TDC in the digital V/T sensor.
- Clears the TDC, launches one rising edge into the chain via o_Target_En, and lets the TDC flops capture it on the next i_Clk_Ref edge.
- Normalises the alternating-polarity capture word and decodes it to a step count.
- Accumulates 2^AVG_LOG2 samples and returns the sum with a valid pulse and error flags; sits between the sensor top-level start/readout logic and the TDC chain.

Parameters:
- N_STEPS, 48: TDC chain length; width of i_TDC_out.
- CNT_W, 6: width of one decoded sample (range 0..N_STEPS).
- AVG_LOG2, 2: log2 of samples per batch (4 samples).
- RST_CYC, 2: cycles the TDC is held in reset before each sample (>=1).

Ports:
- i_Clk_Ref, in, 1: reference clock; also the TDC capture clock.
- i_RST_n, in, 1: reset, asynchronous, active-low.
- i_Start, in, 1: batch request; sampled only in IDLE.
- i_TDC_out, in, N_STEPS: raw TDC capture word.
- o_TDC_Rst_n, out, 1: active-low clear to the TDC flops.
- o_Target_En, out, 1: launch signal driving the TDC chain input.
- o_Busy, out, 1: high in every state except IDLE.
- o_Valid, out, 1: one-cycle pulse; o_Code and flags are valid while it is high.
- o_Code, out, CNT_W+AVG_LOG2: sum of the batch's decoded samples; held until the next o_Valid.
- o_Err, out, 1: bubble detected in any sample of the batch.
- o_Ovf, out, 1: some sample's edge ran off the chain (count == N_STEPS).

Behaviour:
- Reset is i_RST_n, asynchronous, active-low; clock is i_Clk_Ref.
- Reset values: state=IDLE, o_TDC_Rst_n=0, o_Target_En=0, o_Busy=0, o_Valid=0, o_Code=0, o_Err=0, o_Ovf=0, accumulator and sample index = 0.
- All outputs are registered. No combinational path from any input to any output.
- FSM states and outputs:
  - IDLE: o_TDC_Rst_n=0, o_Target_En=0. i_Start=1 -> CLR; clear accumulator, sample index and batch flags.
  - CLR: o_TDC_Rst_n=0, o_Target_En=0 for RST_CYC cycles; the chain settles low. -> ARM.
  - ARM: o_TDC_Rst_n=1, o_Target_En=0, 1 cycle. -> LAUNCH.
  - LAUNCH: o_Target_En=1, 1 cycle. The edge ending LAUNCH is the TDC capture edge. -> WAIT.
  - WAIT: 1 cycle; i_TDC_out is stable and is registered at the edge ending WAIT. -> DECODE.
  - DECODE: decode the registered word, add the count to the accumulator, OR in flags, index++. If index reaches 2^AVG_LOG2 -> DONE, else -> CLR.
  - DONE: o_Valid=1; o_Code = accumulator; o_Err and o_Ovf updated. -> IDLE.
- Decode, normalisation: n[i] = q[i] XOR (i even). A fully settled low chain gives raw 48'h555555555555, i.e. n = 0.
- Decode, count: index of the first 0 in n, scanning from bit 0. Range is 0..N_STEPS.
  - All ones -> count N_STEPS and set the batch Ovf flag.
  - Any 1 above the first 0 (bubble) -> set the batch Err flag; count is unchanged.
- Arithmetic: the accumulator is CNT_W+AVG_LOG2 bits; maximum sum 48*4=192 fits 8 bits, so no saturation is needed.
- Latency: with the edge that samples i_Start counted as edge 0, o_Valid rises at edge 2^AVG_LOG2*(RST_CYC+4)+1. With defaults that is edge 25.
- i_Start while o_Busy=1 is ignored, with no queueing. i_Start held high re-triggers from IDLE one cycle after DONE.
- Reset mid-batch: everything returns to reset values immediately, no o_Valid is produced, and the partial sum is discarded.

Optional Feature:
- Macro TDC_CTRL_BUBBLE_FIX_EN.
- Defined: count = popcount(n), which is bubble-tolerant. Bubble detection logic is removed and o_Err is tied 0.
- Undefined: first-zero count with bubble flag, as specified in Behaviour.
- Ovf detection is identical in both builds.

Test Plan:
1. Reset check: assert i_RST_n=0 mid-idle -> o_TDC_Rst_n=0, o_Target_En=0, o_Busy=0, o_Valid=0, o_Code=0, o_Err=0, o_Ovf=0.
2. Steady count: pulse i_Start; drive i_TDC_out=48'h5555555AAAAA (k=20) in every WAIT -> o_Valid pulses at edge 25, o_Code=80, o_Err=0, o_Ovf=0, o_Busy drops after DONE. Also check o_Target_En is high exactly 1 cycle per sample, 4 times total.
3. Varying samples: feed k=10,11,12,13 in successive samples -> o_Code=46.
4. Overflow: drive i_TDC_out=48'hAAAAAAAAAAAA every sample -> o_Code=192, o_Ovf=1.
5. Bubble: n has ones at bits 0-9 and 11, zeros elsewhere, every sample.
   - Macro undefined -> o_Code=40, o_Err=1.
   - Macro defined -> o_Code=44, o_Err=0.
6. Robustness: pulse i_Start while o_Busy=1 -> ignored, exactly one o_Valid. Assert i_RST_n=0 during the 3rd LAUNCH -> no o_Valid; a new i_Start runs a full 25-edge batch with a correct sum.

Source files
------------

// File: rtl/tdc_meas_ctrl.sv
// ---------------------------------------------------------------------------
// tdc_meas_ctrl
//
// Measurement sequencer for the inverter-chain TDC of the digital V/T sensor.
// For each sample it clears the TDC, arms it, launches one rising edge into
// the chain, registers the captured word, and decodes it to a step count.
// 2^AVG_LOG2 samples are summed and returned with a one-cycle valid pulse and
// batch error/overflow flags.
//
// Build option:
//   TDC_CTRL_BUBBLE_FIX_EN  defined   -> count = popcount of the normalised
//                                        word (bubble tolerant), o_Err tied 0.
//                           undefined -> count = index of the first 0, with
//                                        bubble detection on o_Err.
//
// Ports:
//   i_Clk_Ref    reference clock, also the TDC capture clock
//   i_RST_n      asynchronous active-low reset
//   i_Start      batch request, sampled only while idle
//   i_TDC_out    raw TDC capture word (N_STEPS bits)
//   o_TDC_Rst_n  active-low clear to the TDC flops
//   o_Target_En  launch signal into the TDC chain
//   o_Busy       high whenever a batch is in progress
//   o_Valid      one-cycle pulse, o_Code/o_Err/o_Ovf valid while high
//   o_Code       sum of the batch's decoded samples, held until next o_Valid
//   o_Err        a bubble was seen in some sample of the batch
//   o_Ovf        some sample's edge ran off the end of the chain
// ---------------------------------------------------------------------------
module tdc_meas_ctrl #(
    parameter int N_STEPS  = 48,
    parameter int CNT_W    = 6,
    parameter int AVG_LOG2 = 2,
    parameter int RST_CYC  = 2
) (
    input  logic                      i_Clk_Ref,
    input  logic                      i_RST_n,
    input  logic                      i_Start,
    input  logic [N_STEPS-1:0]        i_TDC_out,
    output logic                      o_TDC_Rst_n,
    output logic                      o_Target_En,
    output logic                      o_Busy,
    output logic                      o_Valid,
    output logic [CNT_W+AVG_LOG2-1:0] o_Code,
    output logic                      o_Err,
    output logic                      o_Ovf
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int IDX_W = AVG_LOG2 + 1;
    localparam int RC_W  = $clog2(RST_CYC + 1);

    localparam logic [IDX_W-1:0] N_SAMPLES = IDX_W'(1 << AVG_LOG2);
    localparam logic [RC_W-1:0]  RST_LAST  = RC_W'(RST_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_ARM,
        ST_LAUNCH,
        ST_WAIT,
        ST_DECODE,
        ST_DONE
    } state_t;

    state_t             state_q,     state_d;
    logic [RC_W-1:0]    rst_cnt_q,   rst_cnt_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic               err_acc_q,   err_acc_d;
    logic               ovf_acc_q,   ovf_acc_d;
    logic [N_STEPS-1:0] tdc_q,       tdc_d;
    logic               tdc_rst_n_q, tdc_rst_n_d;
    logic               target_en_q, target_en_d;
    logic               busy_q,      busy_d;
    logic               valid_q,     valid_d;
    logic [ACC_W-1:0]   code_q,      code_d;
    logic               err_q,       err_d;
    logic               ovf_q,       ovf_d;

    // -----------------------------------------------------------------------
    // Sample decode from the registered capture word
    // -----------------------------------------------------------------------
    logic [N_STEPS-1:0] norm;
    logic [CNT_W-1:0]   samp_cnt;
    logic               samp_ovf;
    logic               samp_bubble;
`ifndef TDC_CTRL_BUBBLE_FIX_EN
    logic               zero_seen;
`endif

    always_comb begin : decode
        // Alternate stages are inverting, so even bits read 1 when the edge
        // has not reached them; flip them so "reached" is always 1.
        for (int i = 0; i < N_STEPS; i++) begin
            norm[i] = tdc_q[i] ^ (i % 2 == 0);
        end
        samp_ovf = &norm;
`ifdef TDC_CTRL_BUBBLE_FIX_EN
        samp_bubble = 1'b0;
        samp_cnt    = '0;
        for (int i = 0; i < N_STEPS; i++) begin
            samp_cnt = samp_cnt + CNT_W'(norm[i]);
        end
`else
        // Count is the position of the first unreached stage; any reached
        // stage beyond it is a bubble and does not change the count.
        samp_bubble = 1'b0;
        samp_cnt    = CNT_W'(N_STEPS);
        zero_seen   = 1'b0;
        for (int i = 0; i < N_STEPS; i++) begin
            if (!zero_seen) begin
                if (!norm[i]) begin
                    samp_cnt  = CNT_W'(i);
                    zero_seen = 1'b1;
                end
            end else if (norm[i]) begin
                samp_bubble = 1'b1;
            end
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin : next_state
        // NOTE: every _d starts from a default so no path leaves it unassigned
        // and no latch is inferred.
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        err_acc_d = err_acc_q;
        ovf_acc_d = ovf_acc_q;
        tdc_d     = tdc_q;
        valid_d   = 1'b0;
        code_d    = code_q;
        err_d     = err_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    state_d   = ST_CLR;
                    rst_cnt_d = '0;
                    idx_d     = '0;
                    acc_d     = '0;
                    err_acc_d = 1'b0;
                    ovf_acc_d = 1'b0;
                end
            end
            ST_CLR: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_ARM;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_ARM:    state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                // The TDC captured at the edge ending LAUNCH; its outputs
                // are settled here and registered at the edge ending WAIT.
                tdc_d   = i_TDC_out;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                acc_d     = acc_q + ACC_W'(samp_cnt);
                err_acc_d = err_acc_q | samp_bubble;
                ovf_acc_d = ovf_acc_q | samp_ovf;
                idx_d     = idx_q + 1'b1;
                state_d   = (idx_d == N_SAMPLES) ? ST_DONE : ST_CLR;
            end
            ST_DONE: begin
                valid_d = 1'b1;
                code_d  = acc_q;
                err_d   = err_acc_q;
                ovf_d   = ovf_acc_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Level outputs are decoded from the next state so the registered
        // copy lines up with the state it describes.
        busy_d      = (state_d != ST_IDLE);
        tdc_rst_n_d = !((state_d == ST_IDLE) || (state_d == ST_CLR));
        target_en_d = (state_d == ST_LAUNCH);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_Clk_Ref or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q     <= ST_IDLE;
            rst_cnt_q   <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            err_acc_q   <= 1'b0;
            ovf_acc_q   <= 1'b0;
            tdc_q       <= '0;
            tdc_rst_n_q <= 1'b0;
            target_en_q <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            code_q      <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            err_acc_q   <= err_acc_d;
            ovf_acc_q   <= ovf_acc_d;
            tdc_q       <= tdc_d;
            tdc_rst_n_q <= tdc_rst_n_d;
            target_en_q <= target_en_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign o_TDC_Rst_n = tdc_rst_n_q;
    assign o_Target_En = target_en_q;
    assign o_Busy      = busy_q;
    assign o_Valid     = valid_q;
    assign o_Code      = code_q;
    assign o_Err       = err_q;
    assign o_Ovf       = ovf_q;

endmodule
